matrix_mult_ctrl: RTL and testbench

Command-side controller for the 4x4x16-bit matrix multiply unit. On a start command it fetches two operand matrices from a 16-bit word memory, packs them into the unit's 256-bit operand buses, and drives the unit's `enable`/`done` handshake. It then captures the 256-bit result and writes it back to memory. It sits between instruction decode and the matrix unit, owning all memory traffic for a matrix-multiply instruction.

---
 rtl/matrix_mult_ctrl.sv | 166 ++++++++++++++++
 tb/tb_matrix_mult_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_ctrl.sv
// Command-side controller for the 4x4x16 matrix unit: fetch two operands, run the unit, write back.
// Define MMC_TIMEOUT_EN to add an EXEC watchdog that raises err and skips writeback.
module matrix_mult_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              cmd_done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic              mem_wr,
    output logic [15:0]       mem_wdata,
    output logic [255:0]      mu_m1,
    output logic [255:0]      mu_m2,
    output logic              mu_enable,
    input  logic              mu_done,
    input  logic [255:0]      mu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_EXEC,
        S_WRITE,
        S_FIN
    } state_t;

    localparam int EXEC_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [ADDR_W-1:0] src1_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [4:0]        cnt;
    logic [EXEC_W-1:0] exec_cnt;
    logic              cap_valid;
    logic [4:0]        cap_idx;
    logic [255:0]      result_q;

    logic [4:0]        cnt_next;
    logic [ADDR_W-1:0] rd_base;
    logic              done_seen;
    logic              timed_out;

    assign cnt_next  = cnt + 5'd1;
    assign rd_base   = cnt_next[4] ? src2_q : src1_q;
    // The first EXEC cycle has exec_cnt == 0; done is only honoured after it.
    assign done_seen = mu_done && (exec_cnt != '0);

`ifdef MMC_TIMEOUT_EN
    assign timed_out = (exec_cnt == EXEC_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: operand and result registers are reset as well, because
            // mu_m1/mu_m2 are visible outputs that must read 0 after reset.
            state     <= S_IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            dst_q     <= '0;
            cnt       <= '0;
            exec_cnt  <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            result_q  <= '0;
            busy      <= 1'b0;
            cmd_done  <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            mu_m1     <= '0;
            mu_m2     <= '0;
            mu_enable <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            cap_valid <= mem_rd;
            cap_idx   <= cnt;

            // Read data arrives one cycle after its request; slot index travels with it.
            if (cap_valid) begin
                if (cap_idx[4]) mu_m2[16*cap_idx[3:0] +: 16] <= mem_rdata;
                else            mu_m1[16*cap_idx[3:0] +: 16] <= mem_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        src1_q   <= src1_addr;
                        src2_q   <= src2_addr;
                        dst_q    <= dst_addr;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= src1_addr;
                        cnt      <= '0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (cnt == 5'd31) begin
                        mem_rd <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        cnt      <= cnt_next;
                        mem_addr <= rd_base + ADDR_W'(cnt_next[3:0]);
                    end
                end
                S_DRAIN: begin
                    mu_enable <= 1'b1;
                    exec_cnt  <= '0;
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    if (done_seen) begin
                        // First write word bypasses result_q, which loads on this same edge.
                        result_q  <= mu_result;
                        mu_enable <= 1'b0;
                        mem_wr    <= 1'b1;
                        mem_addr  <= dst_q;
                        mem_wdata <= mu_result[15:0];
                        cnt       <= '0;
                        state     <= S_WRITE;
                    end else if (timed_out) begin
                        err       <= 1'b1;
                        mu_enable <= 1'b0;
                        cmd_done  <= 1'b1;
                        state     <= S_FIN;
                    end else if (exec_cnt != '1) begin
                        exec_cnt <= exec_cnt + EXEC_W'(1);
                    end
                end
                S_WRITE: begin
                    if (cnt == 5'd15) begin
                        mem_wr   <= 1'b0;
                        cmd_done <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        cnt       <= cnt_next;
                        mem_addr  <= dst_q + ADDR_W'(cnt_next[3:0]);
                        mem_wdata <= result_q[16*cnt_next[3:0] +: 16];
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Self-checking bench for matrix_mult_ctrl: word memory and matrix unit models plus a
// matrix-arithmetic reference; covers identity, ignored start, wrap, in-place, random, reset.
module tb_matrix_mult_ctrl;

    localparam int ADDR_W    = 12;
    localparam int TIMEOUT   = 64;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src1_addr;
    logic [ADDR_W-1:0] src2_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              busy;
    logic              cmd_done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic              mem_wr;
    logic [15:0]       mem_wdata;
    logic [255:0]      mu_m1;
    logic [255:0]      mu_m2;
    logic              mu_enable;
    logic              mu_done;
    logic [255:0]      mu_result;

    logic [15:0]       mem [MEM_WORDS];
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;

    int done_lat  = 0;
    bit hold_done = 1'b0;
    int en_run    = 0;

    int vectors     = 0;
    int miscompares = 0;
    int wr_total    = 0;
    int done_total  = 0;
    int en_total    = 0;
    int ov_total    = 0;
    logic [ADDR_W-1:0] rd_log[$];

    always #5 clk = ~clk;

    matrix_mult_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src1_addr (src1_addr),
        .src2_addr (src2_addr),
        .dst_addr  (dst_addr),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mu_m1     (mu_m1),
        .mu_m2     (mu_m2),
        .mu_enable (mu_enable),
        .mu_done   (mu_done),
        .mu_result (mu_result)
    );

    // Reference: C = A * B over 4x4 matrices of 16-bit words, element (r,c) at word 4r+c.
    function automatic logic [255:0] ref_product(input logic [255:0] a, input logic [255:0] b);
        int unsigned  ma [4][4];
        int unsigned  mb [4][4];
        int unsigned  acc;
        logic [255:0] prod;
        prod = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 32'(a[16*(4*r+c) +: 16]);
                mb[r][c] = 32'(b[16*(4*r+c) +: 16]);
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                for (int i = 0; i < 4; i++) acc += ma[r][i] * mb[i][c];
                prod[16*(4*r+c) +: 16] = acc[15:0];
            end
        end
        return prod;
    endfunction

    function automatic logic [255:0] pack_mem(input logic [ADDR_W-1:0] base);
        logic [255:0]      v;
        logic [ADDR_W-1:0] a;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            a = base + ADDR_W'(k);
            v[16*k +: 16] = mem[a];
        end
        return v;
    endfunction

    // Word memory with one-cycle read latency, plus bus monitors.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_rd) rd_log.push_back(mem_addr);
        if (mem_wr) wr_total <= wr_total + 1;
        if (cmd_done) done_total <= done_total + 1;
        if (mu_enable) en_total <= en_total + 1;
        if (mem_rd && mem_wr) ov_total <= ov_total + 1;
        en_run <= mu_enable ? en_run + 1 : 0;
    end

    // Matrix unit model: done after done_lat enabled cycles, result is the true product.
    assign mu_done = mu_enable && !hold_done && (en_run >= done_lat);
    always_comb mu_result = ref_product(mu_m1, mu_m2);

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic load_rand(input logic [ADDR_W-1:0] base);
        for (int k = 0; k < 16; k++) poke(base + ADDR_W'(k), 16'($urandom));
    endtask

    task automatic load_const(input logic [ADDR_W-1:0] base, input logic [15:0] val);
        for (int k = 0; k < 16; k++) poke(base + ADDR_W'(k), val);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"},      256'(busy),      256'(0));
        check({tag, ".cmd_done"},  256'(cmd_done),  256'(0));
        check({tag, ".err"},       256'(err),       256'(0));
        check({tag, ".mem_rd"},    256'(mem_rd),    256'(0));
        check({tag, ".mem_wr"},    256'(mem_wr),    256'(0));
        check({tag, ".mem_addr"},  256'(mem_addr),  256'(0));
        check({tag, ".mem_wdata"}, 256'(mem_wdata), 256'(0));
        check({tag, ".mu_enable"}, 256'(mu_enable), 256'(0));
        check({tag, ".mu_m1"},     mu_m1,           256'(0));
        check({tag, ".mu_m2"},     mu_m2,           256'(0));
    endtask

    // One full command: expected values come from the memory image and matrix arithmetic.
    task automatic run_cmd(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                           input logic [ADDR_W-1:0] d, input int lat, input int pa,
                           input int pb, input bit exp_to, input string tag);
        logic [255:0]      exp_a, exp_b, exp_c;
        logic [255:0]      exp_rd1, got_rd1, exp_rd2, got_rd2;
        logic [ADDR_W-1:0] a;
        int n, wr0, dn0, en0, ov0, rd0, exec_cycles, exp_lat;

        exp_a       = pack_mem(s1);
        exp_b       = pack_mem(s2);
        exp_c       = ref_product(exp_a, exp_b);
        exec_cycles = exp_to ? TIMEOUT : ((lat + 1 < 2) ? 2 : lat + 1);
        exp_lat     = 34 + exec_cycles + (exp_to ? 0 : 16);
        done_lat    = lat;
        hold_done   = exp_to;
        wr0 = wr_total; dn0 = done_total; en0 = en_total; ov0 = ov_total;
        rd0 = rd_log.size();

        // NOTE: inputs change and outputs are sampled on the falling edge,
        // well away from the rising edge where the DUT samples.
        @(negedge clk);
        src1_addr = s1;
        src2_addr = s2;
        dst_addr  = d;
        start     = 1'b1;
        @(negedge clk);
        n         = 1;
        start     = 1'b0;
        src1_addr = ADDR_W'($urandom);
        src2_addr = ADDR_W'($urandom);
        dst_addr  = ADDR_W'($urandom);
        check({tag, ".busy_after_accept"}, 256'(busy), 256'(1));

        while (!cmd_done && n < 400) begin
            @(negedge clk);
            n++;
            start = (n == pa) || (n == pb);
        end
        start = 1'b0;
        check({tag, ".latency"}, 256'(n), 256'(exp_lat));
        check({tag, ".err"}, 256'(err), 256'(exp_to));
        @(negedge clk);
        check({tag, ".busy_after_done"}, 256'(busy), 256'(0));
        check({tag, ".done_width"}, 256'(cmd_done), 256'(0));
        check({tag, ".writes"}, 256'(wr_total - wr0), 256'(exp_to ? 0 : 16));
        check({tag, ".done_pulses"}, 256'(done_total - dn0), 256'(1));
        check({tag, ".exec_cycles"}, 256'(en_total - en0), 256'(exec_cycles));
        check({tag, ".rd_wr_overlap"}, 256'(ov_total - ov0), 256'(0));
        check({tag, ".reads"}, 256'(rd_log.size() - rd0), 256'(32));
        check({tag, ".mu_m1"}, mu_m1, exp_a);
        check({tag, ".mu_m2"}, mu_m2, exp_b);

        exp_rd1 = '0; got_rd1 = '0; exp_rd2 = '0; got_rd2 = '0;
        for (int k = 0; k < 16; k++) begin
            a = s1 + ADDR_W'(k);
            exp_rd1[ADDR_W*k +: ADDR_W] = a;
            a = s2 + ADDR_W'(k);
            exp_rd2[ADDR_W*k +: ADDR_W] = a;
            if (rd0 + k < rd_log.size())      got_rd1[ADDR_W*k +: ADDR_W] = rd_log[rd0 + k];
            if (rd0 + 16 + k < rd_log.size()) got_rd2[ADDR_W*k +: ADDR_W] = rd_log[rd0 + 16 + k];
        end
        check({tag, ".rd_addr_src1"}, got_rd1, exp_rd1);
        check({tag, ".rd_addr_src2"}, got_rd2, exp_rd2);
        if (!exp_to) check({tag, ".result"}, pack_mem(d), exp_c);
        hold_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_v;
        logic [ADDR_W-1:0] s1, s2, d;
        int n, wr0;

        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        src1_addr = '0; src2_addr = '0; dst_addr = '0;
        #2 reset = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Identity times 1..16 lands 1..16 at 0x020.
        for (int k = 0; k < 16; k++) begin
            poke(ADDR_W'(k), (k / 4 == k % 4) ? 16'd1 : 16'd0);
            poke(ADDR_W'(16 + k), 16'(k + 1));
        end
        run_cmd(12'h000, 12'h010, 12'h020, 0, 0, 0, 1'b0, "ident");
        exp_v = '0;
        for (int k = 0; k < 16; k++) exp_v[16*k +: 16] = 16'(k + 1);
        check("ident.values", pack_mem(12'h020), exp_v);

        // Start strobes mid-command must be ignored.
        load_rand(12'h300);
        load_rand(12'h340);
        run_cmd(12'h300, 12'h340, 12'h380, 1, 5, 40, 1'b0, "pulse");

        // Source and destination wrap past the top of memory.
        load_rand(12'hFF8);
        load_rand(12'h7F0);
        run_cmd(12'hFF8, 12'h7F0, 12'hFFC, 2, 0, 0, 1'b0, "wrap");

        // In-place: result overwrites operand A.
        load_const(12'h100, 16'd2);
        load_const(12'h200, 16'd1);
        run_cmd(12'h100, 12'h200, 12'h100, 0, 0, 0, 1'b0, "inplace");
        exp_v = '0;
        for (int k = 0; k < 16; k++) exp_v[16*k +: 16] = 16'd8;
        check("inplace.values", pack_mem(12'h100), exp_v);

        // Randomized commands: random bases (overlap allowed), operands and unit latency.
        for (int i = 0; i < 6; i++) begin
            s1 = ADDR_W'($urandom);
            s2 = ADDR_W'($urandom);
            d  = ADDR_W'($urandom);
            load_rand(s1);
            load_rand(s2);
            run_cmd(s1, s2, d, int'($urandom_range(0, 5)), 0, 0, 1'b0, $sformatf("rand%0d", i));
        end

`ifdef MMC_TIMEOUT_EN
        load_rand(12'h400);
        load_rand(12'h410);
        run_cmd(12'h400, 12'h410, 12'h420, 0, 0, 0, 1'b1, "timeout");
        run_cmd(12'h400, 12'h410, 12'h420, 0, 0, 0, 1'b0, "after_timeout");
`endif

        // Reset while word 5 of the writeback is on the bus.
        load_rand(12'h500);
        load_rand(12'h510);
        done_lat = 0;
        wr0 = wr_total;
        @(negedge clk);
        src1_addr = 12'h500; src2_addr = 12'h510; dst_addr = 12'h520; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!((wr_total - wr0 == 5) && mem_wr) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid.reached_word5", 256'(n < 200), 256'(1));
        reset = 1'b0;
        #1 check_reset_state("rst_mid");
        repeat (3) @(negedge clk);
        check("rst_mid.no_more_writes", 256'(wr_total - wr0), 256'(5));
        reset = 1'b1;

        run_cmd(12'h500, 12'h510, 12'h530, 0, 0, 0, 1'b0, "recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
